// File: rtl/mod_key_ctrl.sv
// Round-key sequencer for the AES-256 key ROM: walks ROM addresses 0..NR (or NR..0)
// and presents each registered key to the addRoundKey stage with a valid/ready handshake.
module mod_key_ctrl #(
    parameter int NR     = 14,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              dec_mode,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr_romKey,
    input  logic [DATA_W-1:0] key_romKey,
    output logic [DATA_W-1:0] key_out,
    output logic [ADDR_W-1:0] key_round,
    output logic              key_valid,
    output logic              key_last,
    input  logic              key_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NR);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t              state_q, state_d;
    logic                dec_q, dec_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   key_q, key_d;
    logic [ADDR_W-1:0]   round_q, round_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   end_addr;

    // The address register doubles as the round counter.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= S_IDLE;
            dec_q   <= 1'b0;
            addr_q  <= '0;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            addr_q  <= addr_d;
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign end_addr = dec_q ? ADDR_ZERO : ADDR_LAST;

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        addr_d  = addr_q;
        key_d   = key_q;
        round_d = round_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    dec_d   = dec_mode;
                    addr_d  = dec_mode ? ADDR_LAST : ADDR_ZERO;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    key_d   = key_romKey;
                    round_d = addr_q;
                    valid_d = 1'b1;
                    last_d  = (addr_q == end_addr);
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (abort) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (valid_q && key_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // Saturate at the end value so no out-of-range address is issued.
                        if (addr_q != end_addr)
                            addr_d = dec_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    assign addr_romKey = addr_q;
    assign key_out     = key_q;
    assign key_round   = round_q;
    assign key_valid   = valid_q;
    assign key_last    = last_q;
    assign done        = done_q;

endmodule
